// File: rtl/time_display_scan_pkg.sv
// time_display_scan_pkg: segment codes, digit index type and field mask positions
package time_display_scan_pkg;
  localparam logic [6:0] SEG_DIGIT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [1:0] FIELD_SEC = 2'd0;
  localparam logic [1:0] FIELD_MIN = 2'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd2;
  typedef logic [2:0] digit_idx_t;
  function automatic logic [3:0] bcd_tens(logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction
  function automatic logic [3:0] bcd_units(logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction
  function automatic logic [1:0] field_bit(digit_idx_t i);
    return i >= 3'd6 ? FIELD_HOUR : i >= 3'd3 ? FIELD_MIN : FIELD_SEC;
  endfunction
  function automatic logic is_dash(digit_idx_t i);
    return i == 3'd5 || i == 3'd2;
  endfunction
  function automatic logic is_tens(digit_idx_t i);
    return i == 3'd7 || i == 3'd4 || i == 3'd1;
  endfunction
endpackage

// File: rtl/time_display_scan_seg7_decode.sv
// seg7_decode: BCD digit or dash to active-high g..a segment code
module seg7_decode
  import time_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dash,
  output logic [6:0] code
);
  assign code = dash ? SEG_DASH : (bcd <= 4'd9) ? SEG_DIGIT[bcd] : 7'h00;
endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: multiplexed HH-MM-SS seven-segment scanner with snapshot, blink and blank
module time_display_scan
  import time_display_scan_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int SCAN_HZ         = 1_000,
  parameter int BLINK_HZ        = 2,
  parameter bit SEG_ACTIVE_HIGH = 1'b1,
  parameter bit AN_ACTIVE_HIGH  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       blank,
  input  logic [2:0] blink_mask,
  output logic [7:0] seg,
  output logic [7:0] an
);
  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  digit_idx_t idx;
  logic blink_phase, fresh, tick, blink_wrap, load;
  logic [5:0] sh_hour, sh_min, sh_sec, fv;
  logic [3:0] bcd;
  logic [6:0] code;
  logic dash, hide;
  logic [7:0] an_raw, seg_raw;
  seg7_decode u_dec (.bcd(bcd), .dash(dash), .code(code));
  assign tick = tick_cnt == TICK_LAST;
  assign blink_wrap = blink_cnt == BLINK_LAST;
  // the frame boundary is the 7->0 wrap, so a new snapshot starts cleanly at idx 0
  assign load = fresh || (tick && idx == 3'd7);
  always_comb begin
    dash = is_dash(idx);
    fv = idx >= 3'd6 ? sh_hour : idx >= 3'd3 ? sh_min : sh_sec;
    bcd = is_tens(idx) ? bcd_tens(fv) : bcd_units(fv);
    hide = blank || (blink_phase && !dash && blink_mask[field_bit(idx)]);
    an_raw = hide ? 8'h00 : 8'h01 << idx;
    seg_raw = hide ? 8'h00 : {1'b0, code};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      idx <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      fresh <= 1'b1;
      sh_hour <= '0;
      sh_min <= '0;
      sh_sec <= '0;
      seg <= {8{!SEG_ACTIVE_HIGH}};
      an <= {8{!AN_ACTIVE_HIGH}};
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      idx <= tick ? idx + 3'd1 : idx;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase ^ blink_wrap;
      fresh <= 1'b0;
      if (load) begin
        sh_hour <= hour;
        sh_min <= min;
        sh_sec <= sec;
      end
      seg <= seg_raw ^ {8{!SEG_ACTIVE_HIGH}};
      an <= an_raw ^ {8{!AN_ACTIVE_HIGH}};
    end
  end
endmodule
